// File: rtl/exec_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// exec_muldiv_sequencer
//
// Time-shares the execute-stage ALU between the pipeline and an iterative
// unsigned 16x16 multiply (shift-add) / 16/16 divide (restoring) engine.
// While idle the pipeline's ALU request passes straight through. A start
// takes ownership of the ALU for WIDTH add/subtract iterations. During that
// time the pipeline is stalled and flag-register writes are blocked.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i, op_i              request (op 0 = MUL, 1 = DIV), sampled in IDLE
//   op_a_i, op_b_i             multiplicand/multiplier or dividend/divisor
//   pipe_func_i, pipe_in1_i,
//   pipe_in2_i                 pipeline ALU request (passed through in IDLE)
//   alu_func_o, alu_in1_o,
//   alu_in2_o                  to the shared ALU
//   alu_result_i, alu_cout_i   from the shared ALU (cout = carry on ADD,
//                              borrow on SUB)
//   alu_flag_we_o              execute flag register write enable
//   stall_o, busy_o            pipeline freeze / sequencer active
//   done_o                     one-cycle completion pulse
//   result_hi_o, result_lo_o   MUL: product high/low; DIV: remainder/quotient
//   div_by_zero_o              DIV with zero divisor, valid with done_o
// ---------------------------------------------------------------------------
module exec_muldiv_sequencer #(
    parameter int         WIDTH    = 16,
    parameter logic [3:0] FUNC_ADD = 4'd2,
    parameter logic [3:0] FUNC_SUB = 4'd3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [3:0]       pipe_func_i,
    input  logic [WIDTH-1:0] pipe_in1_i,
    input  logic [WIDTH-1:0] pipe_in2_i,
    output logic [3:0]       alu_func_o,
    output logic [WIDTH-1:0] alu_in1_o,
    output logic [WIDTH-1:0] alu_in2_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i,
    output logic             alu_flag_we_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [4:0]       cnt_q, cnt_d;
    // hi_q is the accumulator for MUL and the partial remainder for DIV;
    // opnd_q holds the multiplicand or the divisor.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    // Restoring-divide shift: s is the remainder shifted left with the next
    // dividend bit; div_b is the bit shifted out of the remainder. When it is
    // set the true value is 2^WIDTH + s, which always exceeds the divisor, and
    // the truncated ALU difference is still the correct new remainder.
    logic [WIDTH-1:0] div_s;
    logic             div_b;

    assign div_s = {hi_q[WIDTH-2:0], mq_q[WIDTH-1]};
    assign div_b = hi_q[WIDTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            dbz_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            dbz_q    <= dbz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        dbz_d    = dbz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_o   = 1'b0;

        // Sequencer-owned ALU drive; overridden by the pass-through in IDLE.
        alu_flag_we_o = 1'b0;
        alu_in2_o     = opnd_q;
        if (op_q) begin
            alu_func_o = FUNC_SUB;
            alu_in1_o  = div_s;
        end else begin
            alu_func_o = FUNC_ADD;
            alu_in1_o  = hi_q;
        end

        case (state_q)
            IDLE: begin
                alu_func_o    = pipe_func_i;
                alu_in1_o     = pipe_in1_i;
                alu_in2_o     = pipe_in2_i;
                alu_flag_we_o = 1'b1;
                if (start_i) begin
                    op_d    = op_i;
                    state_d = LOAD;
                    // Operands go straight to their working registers:
                    // MUL shifts the multiplier through mq, DIV the dividend.
                    mq_d    = op_i ? op_a_i : op_b_i;
                    opnd_d  = op_i ? op_b_i : op_a_i;
                end
            end

            LOAD: begin
                hi_d  = '0;
                cnt_d = '0;
                if (op_q && (opnd_q == '0)) begin
                    hi_d    = mq_q;     // remainder = dividend
                    mq_d    = '1;       // quotient saturates
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end

            ITER: begin
                if (!op_q) begin
                    if (mq_q[0]) begin
                        {hi_d, mq_d} = {alu_cout_i, alu_result_i, mq_q[WIDTH-1:1]};
                    end else begin
                        {hi_d, mq_d} = {1'b0, hi_q, mq_q[WIDTH-1:1]};
                    end
                end else begin
                    if (div_b || !alu_cout_i) begin
                        hi_d = alu_result_i;
                        mq_d = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_s;
                        mq_d = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                done_o   = 1'b1;
                res_hi_d = hi_q;
                res_lo_d = mq_q;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign stall_o       = busy_o;
    assign result_hi_o   = res_hi_q;
    assign result_lo_o   = res_lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_exec_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_muldiv_sequencer
//
// Drives directed and random MUL/DIV requests into exec_muldiv_sequencer
// with a behavioural ALU attached. Results are compared against plain
// integer arithmetic (a*b, a/b, a%b). Timing, pass-through and reset
// abort are checked with immediate assertions.
// ---------------------------------------------------------------------------
module tb_exec_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;
    logic [3:0]  pipe_func = '0;
    logic [15:0] pipe_in1 = '0, pipe_in2 = '0;
    logic [3:0]  alu_func;
    logic [15:0] alu_in1, alu_in2, alu_result;
    logic        alu_cout, alu_flag_we, stall, busy, done, div_by_zero;
    logic [15:0] result_hi, result_lo;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    always #5 clk = ~clk;

    exec_muldiv_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_i         (op),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .pipe_func_i  (pipe_func),
        .pipe_in1_i   (pipe_in1),
        .pipe_in2_i   (pipe_in2),
        .alu_func_o   (alu_func),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_result_i (alu_result),
        .alu_cout_i   (alu_cout),
        .alu_flag_we_o(alu_flag_we),
        .stall_o      (stall),
        .busy_o       (busy),
        .done_o       (done),
        .result_hi_o  (result_hi),
        .result_lo_o  (result_lo),
        .div_by_zero_o(div_by_zero)
    );

    // Behavioural shared ALU: ADD gives carry-out, SUB gives borrow.
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_func)
            4'd2:    {alu_cout, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
            4'd3: begin
                alu_result = alu_in1 - alu_in2;
                alu_cout   = (alu_in1 < alu_in2);
            end
            default: alu_result = alu_in1 ^ alu_in2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (txn %0d): observed=0x%0h expected=0x%0h", tag, txn, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle right after DONE, so a following call is back-to-back.
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input bit poke);
        logic [31:0] prod;
        logic [15:0] exp_hi, exp_lo;
        logic        exp_dbz, dbz_at_done;
        int          exp_lat, lat, stl, bad;
        bit          seen;

        if (!o) begin
            prod    = 32'(a) * 32'(b);
            exp_hi  = prod[31:16];
            exp_lo  = prod[15:0];
            exp_dbz = 1'b0;
            exp_lat = 18;
        end else if (b == 16'd0) begin
            exp_hi  = a;
            exp_lo  = 16'hFFFF;
            exp_dbz = 1'b1;
            exp_lat = 2;
        end else begin
            exp_hi  = a % b;
            exp_lo  = a / b;
            exp_dbz = 1'b0;
            exp_lat = 18;
        end

        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        // Operand and pipeline changes after the start edge must not matter.
        start = 1'b0; op = ~o; op_a = 16'($urandom); op_b = 16'($urandom);
        pipe_func = 4'($urandom); pipe_in1 = 16'($urandom); pipe_in2 = 16'($urandom);

        lat = 0; stl = 0; bad = 0; seen = 1'b0; dbz_at_done = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (stall) stl++;
            if (!busy || (stall !== busy) || (alu_flag_we !== 1'b0)) bad++;
            if (done) begin
                seen        = 1'b1;
                lat         = c + 1;
                dbz_at_done = div_by_zero;
            end else if (poke) begin
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;

        chk("done_seen",    32'(seen),        32'd1);
        chk("done_latency", 32'(lat),         32'(exp_lat));
        chk("stall_cycles", 32'(stl),         32'(exp_lat));
        chk("busy_invar",   32'(bad),         32'd0);
        chk("dbz_at_done",  32'(dbz_at_done), 32'(exp_dbz));

        @(negedge clk);
        chk("idle_busy",    32'(busy),        32'd0);
        chk("idle_stall",   32'(stall),       32'd0);
        chk("idle_done",    32'(done),        32'd0);
        chk("result_hi",    32'(result_hi),   32'(exp_hi));
        chk("result_lo",    32'(result_lo),   32'(exp_lo));
        chk("div_by_zero",  32'(div_by_zero), 32'(exp_dbz));
        $display("txn %0d: %s a=0x%04h b=0x%04h -> hi=0x%04h lo=0x%04h dbz=%0b lat=%0d",
                 txn, o ? "DIV" : "MUL", a, b, result_hi, result_lo, div_by_zero, lat);
        txn++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;

        // Reset state
        #2;
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_stall",   32'(stall),       32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_flag_we", 32'(alu_flag_we), 32'd1);
        chk("rst_res_hi",  32'(result_hi),   32'd0);
        chk("rst_res_lo",  32'(result_lo),   32'd0);
        chk("rst_dbz",     32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle pass-through
        pipe_func = 4'd5; pipe_in1 = 16'd3; pipe_in2 = 16'd4;
        #1;
        chk("pass_func",    32'(alu_func),    32'd5);
        chk("pass_in1",     32'(alu_in1),     32'd3);
        chk("pass_in2",     32'(alu_in2),     32'd4);
        chk("pass_flag_we", 32'(alu_flag_we), 32'd1);
        @(negedge clk);

        // Directed operations, back-to-back
        run_op(1'b0, 16'h00FF, 16'h0101, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        run_op(1'b1, 16'd100,  16'd7,    1'b0);
        run_op(1'b1, 16'hFFFF, 16'h8001, 1'b1);
        run_op(1'b1, 16'h1234, 16'h0000, 1'b0);
        run_op(1'b0, 16'h0000, 16'hABCD, 1'b0);
        run_op(1'b1, 16'h0005, 16'h0009, 1'b0);

        // Random operations with occasional zero divisors and start pokes
        for (int i = 0; i < 20; i++) begin
            logic        ro;
            logic [15:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            run_op(ro, ra, rb, (i % 2) == 1);
            if (i % 3 == 0) @(negedge clk);
        end

        // Leave non-zero results behind, then abort a MUL mid-iteration
        run_op(1'b1, 16'd100, 16'd7, 1'b0);
        start = 1'b1; op = 1'b0; op_a = 16'h1234; op_b = 16'h00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);   // LOAD, then ITER with cnt 0..7
        rst_n = 1'b0;
        #1;
        chk("abort_busy",    32'(busy),        32'd0);
        chk("abort_stall",   32'(stall),       32'd0);
        chk("abort_done",    32'(done),        32'd0);
        chk("abort_flag_we", 32'(alu_flag_we), 32'd1);
        chk("abort_res_hi",  32'(result_hi),   32'd0);
        chk("abort_res_lo",  32'(result_lo),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        run_op(1'b0, 16'd3, 16'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
